// File: rtl/nco_hop_pkg.sv
// Shared types and defaults for the NCO frequency-hop scheduler.
package nco_hop_pkg;

    localparam int NCO_LAT_DEF = 10;
    localparam int APR_W       = 32;
    localparam int DWW_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } hop_state_e;

    typedef struct packed {
        logic [APR_W-1:0] phi;
        logic [DWW_W-1:0] dwell;
    } hop_entry_t;

endpackage

// File: rtl/nco_hop_tagpipe.sv
// Enable-gated delay line carrying {valid, hop index} alongside the NCO pipeline.
module nco_hop_tagpipe #(
    parameter int DEPTH = 10,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/nco_hop_sched.sv
// Steps the NCO phase increment through a table of {phi, dwell} hops, once or looped,
// and tags each NCO output sample with the hop that produced it.
module nco_hop_sched
    import nco_hop_pkg::*;
#(
    parameter int apr     = APR_W,
    parameter int nhop    = 8,
    parameter int lognhop = 3,
    parameter int dww     = DWW_W,
    parameter int nco_lat = NCO_LAT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [lognhop-1:0] cfg_addr,
    input  logic [apr-1:0]     cfg_phi,
    input  logic [dww-1:0]     cfg_dwell,
    input  logic [lognhop-1:0] cfg_last,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    input  logic               sample_en,
    output logic [apr-1:0]     phi_inc_o,
    output logic               clken_o,
    output logic               busy,
    output logic               hop_strobe,
    output logic [lognhop-1:0] hop_idx_o,
    output logic [lognhop-1:0] out_tag,
    output logic               tag_valid,
    output logic               done
);

    localparam int DCW = $clog2(nco_lat + 1);

    hop_entry_t         hop_tbl_q [nhop];
    hop_state_e         state_q, state_d;
    logic [lognhop-1:0] idx_q, idx_d, last_q, last_d, load_idx;
    logic [dww-1:0]     dwell_q, dwell_d;
    logic [apr-1:0]     phi_q, phi_d;
    logic [DCW-1:0]     drain_q, drain_d;
    logic               loop_q, loop_d;
    logic               hop_strobe_q, hop_strobe_d;
    logic               done_q, done_d;
    logic               hop_load, pipe_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < nhop; i++) hop_tbl_q[i] <= '0;
        end else if (cfg_we && !busy) begin
            hop_tbl_q[cfg_addr] <= '{phi: cfg_phi, dwell: cfg_dwell};
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_d       = last_q;
        loop_d       = loop_q;
        dwell_d      = dwell_q;
        phi_d        = phi_q;
        drain_d      = drain_q;
        hop_strobe_d = 1'b0;
        done_d       = 1'b0;
        hop_load     = 1'b0;
        pipe_clr     = 1'b0;
        load_idx     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    last_d   = cfg_last;
                    loop_d   = loop;
                    hop_load = 1'b1;
                    pipe_clr = 1'b1;
                end
            end
            RUN: begin
                // stop beats a hop boundary on the same sample
                if (stop) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else if (sample_en) begin
                    if (dwell_q == dww'(1)) begin
                        if (idx_q != last_q) begin
                            hop_load = 1'b1;
                            load_idx = idx_q + lognhop'(1);
                        end else if (loop_q) begin
                            hop_load = 1'b1;
                        end else begin
                            state_d = DRAIN;
                            drain_d = '0;
                        end
                    end else begin
                        dwell_d = dwell_q - dww'(1);
                    end
                end
            end
            DRAIN: begin
                if (sample_en) begin
                    if (drain_q == DCW'(nco_lat - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + DCW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (hop_load) begin
            idx_d        = load_idx;
            phi_d        = hop_tbl_q[load_idx].phi;
            dwell_d      = (hop_tbl_q[load_idx].dwell == '0) ? dww'(1) : hop_tbl_q[load_idx].dwell;
            hop_strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_q       <= '0;
            loop_q       <= 1'b0;
            dwell_q      <= '0;
            phi_q        <= '0;
            drain_q      <= '0;
            hop_strobe_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            loop_q       <= loop_d;
            dwell_q      <= dwell_d;
            phi_q        <= phi_d;
            drain_q      <= drain_d;
            hop_strobe_q <= hop_strobe_d;
            done_q       <= done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign clken_o    = sample_en & busy;
    assign phi_inc_o  = phi_q;
    assign hop_idx_o  = idx_q;
    assign hop_strobe = hop_strobe_q;
    assign done       = done_q;

    nco_hop_tagpipe #(
        .DEPTH(nco_lat),
        .W    (lognhop + 1)
    ) u_tagpipe (
        .clk  (clk),
        .reset(reset),
        .clr_i(pipe_clr),
        .en_i (clken_o),
        .d_i  ({state_q == RUN, idx_q}),
        .q_o  ({tag_valid, out_tag})
    );

endmodule

// File: tb/tb_nco_hop_sched.sv
// Randomised scoreboard bench for nco_hop_sched: a sequence-level model predicts every issued sample.
module tb_nco_hop_sched;

    localparam int LAT  = 10;
    localparam int NHOP = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_phi;
    logic [15:0] cfg_dwell;
    logic [2:0]  cfg_last;
    logic        loop;
    logic        start;
    logic        stop;
    logic        sample_en;
    logic [31:0] phi_inc_o;
    logic        clken_o;
    logic        busy;
    logic        hop_strobe;
    logic [2:0]  hop_idx_o;
    logic [2:0]  out_tag;
    logic        tag_valid;
    logic        done;

    nco_hop_sched dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_phi(cfg_phi),
        .cfg_dwell(cfg_dwell), .cfg_last(cfg_last), .loop(loop), .start(start), .stop(stop),
        .sample_en(sample_en), .phi_inc_o(phi_inc_o), .clken_o(clken_o), .busy(busy),
        .hop_strobe(hop_strobe), .hop_idx_o(hop_idx_o), .out_tag(out_tag),
        .tag_valid(tag_valid), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] phi;
        logic [2:0]  idx;
        logic        vld;
        int          n;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        hist  [$];
    int          strobe_cyc [$];
    logic [31:0] m_phi [NHOP];
    int          m_dw  [NHOP];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_pop_cyc = -100;
    int          t0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    // Monitor: every issued sample is matched against the next prediction.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] tag_exp;
        if (!reset) begin
            if (hop_strobe) strobe_cyc.push_back(cyc);
            if (clken_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.n == 0) hist.delete();
                    hist.push_back(e);
                    chk("phi_inc", phi_inc_o, e.phi);
                    chk("hop_idx", hop_idx_o, e.idx);
                    tag_exp = (e.n >= LAT) ? {hist[e.n-LAT].vld, hist[e.n-LAT].idx} : 4'h0;
                    chk("out_tag", {tag_valid, out_tag}, tag_exp);
                    last_pop_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy_low", busy, 0);
                chk("done_all_drained", exp_q.size(), 0);
                chk("done_timing", cyc, last_pop_cyc + 1);
            end
        end
    end

    // Predicts the sample stream of one sequence: RUN samples then the drain samples.
    task automatic gen(input int last, input bit lp, input int stop_after, input bit stop_sim,
                       output int loads);
        int idx, rem, n, limit;
        bit ended;
        limit = (stop_after < 0) ? 1000000 : stop_after + int'(stop_sim);
        idx = 0; n = 0; loads = 1; ended = 0;
        rem = eff(m_dw[0]);
        while (n < limit && !ended) begin
            exp_q.push_back('{phi: m_phi[idx], idx: 3'(idx), vld: 1'b1, n: n});
            n++;
            rem--;
            if (rem == 0) begin
                if (idx == last && !lp) ended = 1;
                else if (!(stop_sim && n == limit)) begin
                    idx = (idx == last) ? 0 : idx + 1;
                    rem = eff(m_dw[idx]);
                    loads++;
                end
            end
        end
        for (int i = 0; i < LAT; i++) begin
            exp_q.push_back('{phi: m_phi[idx], idx: 3'(idx), vld: 1'b0, n: n});
            n++;
        end
    endtask

    task automatic wr(input int a, input logic [31:0] phi, input int dw);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_phi = phi; cfg_dwell = 16'(dw);
        step();
        cfg_we = 1'b0;
        m_phi[a] = phi; m_dw[a] = dw;
    endtask

    // en_pct < 0 selects a strict 1010... sample_en pattern.
    task automatic run_seq(input int last, input bit lp, input int stop_after, input bit stop_sim,
                           input int en_pct, input bit poke);
        int loads, d0, k, cnt;
        bit stopped;
        gen(last, lp, stop_after, stop_sim, loads);
        strobe_cyc.delete();
        d0 = done_cnt;
        cfg_last = 3'(last); loop = lp; start = 1'b1; t0 = cyc;
        step();
        start = 1'b0; cfg_last = 3'd0; loop = 1'b0;
        k = 0; cnt = 0; stopped = (stop_after < 0);
        while (done_cnt == d0 && k < 3000) begin
            stop = 1'b0; cfg_we = 1'b0; start = 1'b0;
            if (!stopped && cnt == stop_after) begin
                stop = 1'b1; sample_en = stop_sim; stopped = 1;
            end else begin
                sample_en = (en_pct < 0) ? ~k[0] : ($urandom_range(99) < en_pct);
                if (sample_en && !stopped) cnt++;
            end
            if (poke && k == 1) begin
                cfg_we = 1'b1; cfg_addr = 3'd0; cfg_phi = $urandom; cfg_dwell = 16'($urandom_range(9));
                start = 1'b1;
            end
            step();
            k++;
        end
        stop = 1'b0; sample_en = 1'b0; cfg_we = 1'b0; start = 1'b0;
        chk("done_seen", done_cnt - d0, 1);
        chk("hop_strobe_count", strobe_cyc.size(), loads);
        chk("queue_empty", exp_q.size(), 0);
        repeat (2) step();
    endtask

    initial begin
        int total, lst, d0;
        bit lp;
        reset = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_phi = 0; cfg_dwell = 0; cfg_last = 0;
        loop = 0; start = 0; stop = 0; sample_en = 0;
        for (int i = 0; i < NHOP; i++) begin m_phi[i] = '0; m_dw[i] = 0; end
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_outputs", {phi_inc_o, clken_o, busy, hop_strobe, hop_idx_o, out_tag, tag_valid, done}, 0);

        // two-hop single pass with continuous samples
        wr(0, 32'h0100_0000, 3);
        wr(1, 32'h0200_0000, 2);
        run_seq(1, 0, -1, 0, 100, 0);
        chk("strobe0_time", strobe_cyc.size() > 0 ? strobe_cyc[0] : -1, t0 + 1);
        chk("strobe1_time", strobe_cyc.size() > 1 ? strobe_cyc[1] : -1, t0 + 4);
        chk("done_time", done_cyc, t0 + 16);

        // looped, stopped after 12 samples; then stop landing on a hop boundary
        run_seq(1, 1, 12, 0, 100, 0);
        run_seq(1, 1, 2, 1, 100, 0);

        // zero dwell on entry 0
        wr(0, 32'h0123_4567, 0);
        run_seq(1, 0, -1, 0, 60, 0);

        // alternating sample_en, looped, stopped together with a sample
        wr(0, 32'h0100_0000, 3);
        run_seq(1, 1, 9, 1, -1, 0);

        // random tables, with table writes and start pulses issued while busy
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < NHOP; a++) wr(a, $urandom, $urandom_range(5));
            lst = $urandom_range(7);
            lp = 1'($urandom_range(1));
            total = 0;
            for (int a = 0; a <= lst; a++) total += eff(m_dw[a]);
            if (lp) run_seq(lst, 1, $urandom_range(40, 1), 1'($urandom_range(1)), $urandom_range(100, 30), 1);
            else    run_seq(lst, 0, (r % 2 == 0) ? -1 : $urandom_range(total - 1), 1'($urandom_range(1)),
                            $urandom_range(100, 30), 1);
        end

        // reset mid-run
        wr(0, 32'h0100_0000, 3);
        wr(1, 32'h0200_0000, 2);
        gen(1, 0, -1, 0, total);
        cfg_last = 3'd1; loop = 1'b0; start = 1'b1;
        step();
        start = 1'b0; sample_en = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        exp_q.delete();
        #2;
        chk("reset_mid_run", {phi_inc_o, clken_o, busy, hop_strobe, hop_idx_o, out_tag, tag_valid, done}, 0);
        d0 = done_cnt;
        repeat (3) step();
        reset = 1'b0; sample_en = 1'b0;
        for (int i = 0; i < NHOP; i++) begin m_phi[i] = '0; m_dw[i] = 0; end
        repeat (3) step();
        chk("no_done_on_reset", done_cnt, d0);

        // table must come back cleared; then a normal run after reload
        run_seq(0, 0, -1, 0, 100, 0);
        wr(0, 32'h0100_0000, 3);
        wr(1, 32'h0200_0000, 2);
        run_seq(1, 1, 14, 0, 70, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
